// File: rtl/fir_decimator.sv
// fir_decimator: decimate-by-DECIM_FACTOR stage behind the FIR filter.
// Keeps the accepted beat whose index within each group equals DECIM_PHASE.
// Kept beats go through a 2-entry skid buffer, so output backpressure never
// drops data. A tlast on a dropped beat is carried forward to the next kept
// beat.
// Optional build macro: FIR_DECIM_FRAME_ALIGN_EN. When it is defined, any
// accepted beat with tlast restarts the phase counter at 0.
module fir_decimator #(
   parameter int DATA_WIDTH   = 16,
   parameter int DECIM_FACTOR = 4,
   parameter int DECIM_PHASE  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_axis_dec_tdata,
   input  logic                  s_axis_dec_tvalid,
   output logic                  s_axis_dec_tready,
   input  logic                  s_axis_dec_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_dec_tdata,
   output logic                  m_axis_dec_tvalid,
   input  logic                  m_axis_dec_tready,
   output logic                  m_axis_dec_tlast,
   output logic [((DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1)-1:0] dec_phase
);

   localparam int PW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
   localparam logic [PW-1:0] PHASE_K = PW'(DECIM_PHASE);
   localparam logic [PW-1:0] LAST_K  = PW'((DECIM_FACTOR > 1) ? DECIM_FACTOR - 1 : 0);

   if (DECIM_FACTOR < 1) begin : g_bad_factor
      $error("fir_decimator: DECIM_FACTOR must be >= 1");
   end
   if (DECIM_PHASE < 0 || DECIM_PHASE >= DECIM_FACTOR) begin : g_bad_phase
      $error("fir_decimator: DECIM_PHASE must be in 0..DECIM_FACTOR-1");
   end

   logic [PW-1:0]         phase_q, phase_d;
   logic                  pend_q, pend_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  s_ready_q, s_ready_d;
   logic [DATA_WIDTH-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
   logic                  e0_last_q, e0_last_d, e1_last_q, e1_last_d;

   logic accept, keep, pop, in_last;

   assign accept  = s_axis_dec_tvalid & s_ready_q;
   assign keep    = accept & (phase_q == PHASE_K);
   assign pop     = (cnt_q != 2'd0) & m_axis_dec_tready;
   assign in_last = s_axis_dec_tlast | pend_q;

   // Next-state for phase counter, carried tlast and the skid buffer.
   always_comb begin
      phase_d   = phase_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      e0_data_d = e0_data_q;
      e0_last_d = e0_last_q;
      e1_data_d = e1_data_q;
      e1_last_d = e1_last_q;

      if (accept) begin
         phase_d = (phase_q == LAST_K) ? '0 : phase_q + 1'b1;
`ifdef FIR_DECIM_FRAME_ALIGN_EN
         if (s_axis_dec_tlast) begin
            phase_d = '0;
         end
`endif
         if (keep) begin
            pend_d = 1'b0;
         end else if (s_axis_dec_tlast) begin
            pend_d = 1'b1;
         end
      end

      case ({keep, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               e0_data_d = s_axis_dec_tdata;
               e0_last_d = in_last;
               cnt_d     = 2'd1;
            end else begin
               e1_data_d = s_axis_dec_tdata;
               e1_last_d = in_last;
               cnt_d     = 2'd2;
            end
         end
         2'b01: begin
            e0_data_d = e1_data_q;
            e0_last_d = e1_last_q;
            cnt_d     = cnt_q - 2'd1;
         end
         2'b11: begin
            // Push while popping: a full buffer cannot accept, so this is
            // the count-1 case; the new beat replaces the head directly.
            if (cnt_q == 2'd2) begin
               e0_data_d = e1_data_q;
               e0_last_d = e1_last_q;
               e1_data_d = s_axis_dec_tdata;
               e1_last_d = in_last;
            end else begin
               e0_data_d = s_axis_dec_tdata;
               e0_last_d = in_last;
            end
         end
         default: ;
      endcase

      s_ready_d = (cnt_d < 2'd2);
   end

   // State registers; reset discards buffered beats and drops ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q   <= '0;
         pend_q    <= 1'b0;
         cnt_q     <= 2'd0;
         s_ready_q <= 1'b0;
         e0_data_q <= '0;
         e0_last_q <= 1'b0;
         e1_data_q <= '0;
         e1_last_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         s_ready_q <= s_ready_d;
         e0_data_q <= e0_data_d;
         e0_last_q <= e0_last_d;
         e1_data_q <= e1_data_d;
         e1_last_q <= e1_last_d;
      end
   end

   assign s_axis_dec_tready = s_ready_q;
   assign m_axis_dec_tvalid = (cnt_q != 2'd0);
   assign m_axis_dec_tdata  = e0_data_q;
   assign m_axis_dec_tlast  = e0_last_q;
   assign dec_phase         = phase_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: instance dut (D=4,P=0), instance dut1 (D=4,P=1).
module tb_fir_decimator;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic [15:0] s_tdata, m_tdata, s1_tdata, m1_tdata;
   logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
   logic        s1_tvalid, s1_tready, s1_tlast, m1_tvalid, m1_tready, m1_tlast;
   logic [1:0]  phase, phase1;

   fir_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(4), .DECIM_PHASE(0)) dut (
      .clk(clk), .reset(reset),
      .s_axis_dec_tdata(s_tdata), .s_axis_dec_tvalid(s_tvalid),
      .s_axis_dec_tready(s_tready), .s_axis_dec_tlast(s_tlast),
      .m_axis_dec_tdata(m_tdata), .m_axis_dec_tvalid(m_tvalid),
      .m_axis_dec_tready(m_tready), .m_axis_dec_tlast(m_tlast),
      .dec_phase(phase));

   fir_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(4), .DECIM_PHASE(1)) dut1 (
      .clk(clk), .reset(reset),
      .s_axis_dec_tdata(s1_tdata), .s_axis_dec_tvalid(s1_tvalid),
      .s_axis_dec_tready(s1_tready), .s_axis_dec_tlast(s1_tlast),
      .m_axis_dec_tdata(m1_tdata), .m_axis_dec_tvalid(m1_tvalid),
      .m_axis_dec_tready(m1_tready), .m_axis_dec_tlast(m1_tlast),
      .dec_phase(phase1));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc_cyc [256];
   int acc_n, stall_n;
   int od[$], ol[$], oc[$];
   int od1[$], ol1[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset && m_tvalid && m_tready) begin
         od.push_back(int'(m_tdata));
         ol.push_back(int'(m_tlast));
         oc.push_back(cyc);
      end
      if (reset && m1_tvalid && m1_tready) begin
         od1.push_back(int'(m1_tdata));
         ol1.push_back(int'(m1_tlast));
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Offer one beat (inputs change at posedge+1) and return after it is taken.
   task automatic send(input bit which, input int d, input bit last);
      int t;
      t = 0;
      if (!which) begin
         s_tdata = d[15:0]; s_tlast = last; s_tvalid = 1'b1;
         while (!s_tready && t < 100) begin @(posedge clk); #1; t++; end
      end else begin
         s1_tdata = d[15:0]; s1_tlast = last; s1_tvalid = 1'b1;
         while (!s1_tready && t < 100) begin @(posedge clk); #1; t++; end
      end
      stall_n += t;
      if (t >= 100) begin
         check("send_timeout", t, 0);
      end else begin
         acc_cyc[d & 255] = cyc;
         acc_n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      s1_tvalid = 1'b0; s1_tlast = 1'b0;
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      od.delete(); ol.delete(); oc.delete(); od1.delete(); ol1.delete();
   endtask

   task automatic chk_out(input string tag, input bit which, input int i, input int d, input int l);
      if (!which && i < od.size()) begin
         check({tag, "_data"}, od[i], d);
         check({tag, "_last"}, ol[i], l);
      end else if (which && i < od1.size()) begin
         check({tag, "_data"}, od1[i], d);
         check({tag, "_last"}, ol1[i], l);
      end else begin
         check({tag, "_missing"}, which ? od1.size() : od.size(), i + 1);
      end
   endtask

   initial begin
      int k;
      reset = 1'b0;
      m_tready = 1'b1; m1_tready = 1'b1;
      s_tdata = '0; s1_tdata = '0;
      idle();
      acc_n = 0; stall_n = 0;
      #12;
      check("rst_m_tvalid", int'(m_tvalid), 0);
      check("rst_s_tready", int'(s_tready), 0);
      check("rst_m_tdata", int'(m_tdata), 0);
      check("rst_m_tlast", int'(m_tlast), 0);
      check("rst_phase", int'(phase), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      check("rel_s_tready_pre_edge", int'(s_tready), 0);
      @(posedge clk); #1;
      check("rel_s_tready_post_edge", int'(s_tready), 1);

      // 1: back-to-back 0..11, no backpressure
      clear_q(); stall_n = 0;
      for (int i = 0; i < 12; i++) send(0, i, 1'b0);
      idle(); drain();
      check("t1_count", od.size(), 3);
      chk_out("t1_o0", 0, 0, 0, 0);
      chk_out("t1_o1", 0, 1, 4, 0);
      chk_out("t1_o2", 0, 2, 8, 0);
      for (int i = 0; i < od.size(); i++) check("t1_latency", oc[i], acc_cyc[od[i] & 255] + 1);
      check("t1_stalls", stall_n, 0);
      check("t1_phase", int'(phase), 0);

      // 2: output stalled for 30 cycles while 0..15 are offered
      clear_q(); acc_n = 0; m_tready = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) send(0, i, 1'b0);
            idle();
         end
         begin
            repeat (30) @(posedge clk);
            #2;
            check("t2_accepted_while_full", acc_n, 5);
            check("t2_s_tready_full", int'(s_tready), 0);
            check("t2_m_tvalid_held", int'(m_tvalid), 1);
            check("t2_m_tdata_held", int'(m_tdata), 0);
            check("t2_phase_held", int'(phase), 1);
            m_tready = 1'b1;
         end
      join
      drain();
      check("t2_count", od.size(), 4);
      chk_out("t2_o0", 0, 0, 0, 0);
      chk_out("t2_o1", 0, 1, 4, 0);
      chk_out("t2_o2", 0, 2, 8, 0);
      chk_out("t2_o3", 0, 3, 12, 0);

      // 3: tlast on dropped beat 6
      clear_q();
      for (int i = 0; i < 16; i++) send(0, i, i == 6);
      idle(); drain();
`ifdef FIR_DECIM_FRAME_ALIGN_EN
      check("t3_count", od.size(), 5);
      chk_out("t3_o0", 0, 0, 0, 0);
      chk_out("t3_o1", 0, 1, 4, 0);
      chk_out("t3_o2", 0, 2, 7, 1);
      chk_out("t3_o3", 0, 3, 11, 0);
      chk_out("t3_o4", 0, 4, 15, 0);
`else
      check("t3_count", od.size(), 4);
      chk_out("t3_o0", 0, 0, 0, 0);
      chk_out("t3_o1", 0, 1, 4, 0);
      chk_out("t3_o2", 0, 2, 8, 1);
      chk_out("t3_o3", 0, 3, 12, 0);
`endif

      // 4: phase 1 instance, tlast on kept beat 5
      clear_q();
      for (int i = 0; i < 12; i++) send(1, i, i == 5);
      idle(); drain();
`ifdef FIR_DECIM_FRAME_ALIGN_EN
      check("t4_count", od1.size(), 4);
      chk_out("t4_o0", 1, 0, 1, 0);
      chk_out("t4_o1", 1, 1, 5, 1);
      chk_out("t4_o2", 1, 2, 7, 0);
      chk_out("t4_o3", 1, 3, 11, 0);
`else
      check("t4_count", od1.size(), 3);
      chk_out("t4_o0", 1, 0, 1, 0);
      chk_out("t4_o1", 1, 1, 5, 1);
      chk_out("t4_o2", 1, 2, 9, 0);
`endif

      // 5: fill both entries, then async reset mid-cycle
      m_tready = 1'b0; k = 0;
      repeat (20) begin
         s_tdata = k[15:0]; s_tlast = 1'b0; s_tvalid = 1'b1;
         if (s_tready) k++;
         @(posedge clk); #1;
      end
      idle();
      check("t5_full_m_tvalid", int'(m_tvalid), 1);
      check("t5_full_s_tready", int'(s_tready), 0);
      #3;
      reset = 1'b0;
      #1;
      check("t5_rst_m_tvalid", int'(m_tvalid), 0);
      check("t5_rst_s_tready", int'(s_tready), 0);
      check("t5_rst_m_tdata", int'(m_tdata), 0);
      check("t5_rst_m_tlast", int'(m_tlast), 0);
      check("t5_rst_phase", int'(phase), 0);
      m_tready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      clear_q();
      for (int i = 100; i < 104; i++) send(0, i, 1'b0);
      idle(); drain();
      check("t5_count", od.size(), 1);
      chk_out("t5_o0", 0, 0, 100, 0);
      check("t5_phase", int'(phase), 0);

      // 6: frame 0..5 (tlast on 5) followed by 6..13
      clear_q();
      for (int i = 0; i < 14; i++) send(0, i, i == 5);
      idle(); drain();
      check("t6_count", od.size(), 4);
      chk_out("t6_o0", 0, 0, 0, 0);
      chk_out("t6_o1", 0, 1, 4, 0);
`ifdef FIR_DECIM_FRAME_ALIGN_EN
      chk_out("t6_o2", 0, 2, 6, 1);
      chk_out("t6_o3", 0, 3, 10, 0);
`else
      chk_out("t6_o2", 0, 2, 8, 1);
      chk_out("t6_o3", 0, 3, 12, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
